// File: rtl/monitor_alarmas_pkg.sv
// Shared definitions for the alarm monitor: FSM state encoding and cause bit indices.
package monitor_alarmas_pkg;

  localparam logic [2:0] ST_INICIO   = 3'd0;
  localparam logic [2:0] ST_CHK_TEMP = 3'd1;
  localparam logic [2:0] ST_CHK_CORR = 3'd2;
  localparam logic [2:0] ST_CHK_HUMO = 3'd3;
  localparam logic [2:0] ST_ALERTA   = 3'd4;
  localparam logic [2:0] ST_PREVEN   = 3'd5;

  typedef enum logic [2:0] {
    INICIO   = ST_INICIO,
    CHK_TEMP = ST_CHK_TEMP,
    CHK_CORR = ST_CHK_CORR,
    CHK_HUMO = ST_CHK_HUMO,
    ALERTA   = ST_ALERTA,
    PREVEN   = ST_PREVEN
  } estado_t;

  localparam int CAUSA_TEMP = 0;
  localparam int CAUSA_CORR = 1;
  localparam int CAUSA_HUMO = 2;

  function automatic logic es_alarma(input estado_t st);
    return (st == ALERTA) || (st == PREVEN);
  endfunction

endpackage

// File: rtl/filtro_persistencia.sv
// Persistence filter: output follows input only after DEB consecutive equal samples.
module filtro_persistencia #(
  parameter int DEB = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [3:0] cnt_r;
  logic       dout_r;

  // Count consecutive samples that disagree with the filtered value
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= 4'd0;
      dout_r <= 1'b0;
    end else if (din == dout_r) begin
      cnt_r  <= 4'd0;
    end else if (cnt_r == 4'(DEB - 1)) begin
      cnt_r  <= 4'd0;
      dout_r <= din;
    end else begin
      cnt_r  <= cnt_r + 4'd1;
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/monitor_alarmas.sv
// Alarm monitor: scans filtered temp/current/smoke flags and raises alert or prevention alarms.
// Define MONITOR_ALARMAS_LATCH_EN to require an operator ack before an alarm is released.
module monitor_alarmas
  import monitor_alarmas_pkg::*;
#(
  parameter int          N      = 5,
  parameter int unsigned UMBRAL = 15,
  parameter int          DEB    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         interruptor,
  input  logic         temp,
  input  logic         humo,
  input  logic [N-1:0] corriente,
  input  logic         ack,
  output logic         LEDalerta,
  output logic         LEDprevencion,
  output logic         LEDnormal,
  output logic         alarma_alerta,
  output logic         alarma_prevencion,
  output logic [2:0]   causa,
  output logic [7:0]   cont_eventos
);

  localparam logic [N-1:0] UMBRAL_N = N'(UMBRAL);

  estado_t    estado_r, estado_next_s;
  logic [2:0] causa_r, causa_next_s;
  logic [7:0] cont_r;
  logic       c_raw_s, temp_f_s, corr_f_s, humo_f_s;
  logic       flag_causa_s, salir_s;

  assign c_raw_s = (corriente >= UMBRAL_N);

  filtro_persistencia #(.DEB(DEB)) u_filtro_temp (.clk(clk), .rst(rst), .din(temp),    .dout(temp_f_s));
  filtro_persistencia #(.DEB(DEB)) u_filtro_corr (.clk(clk), .rst(rst), .din(c_raw_s), .dout(corr_f_s));
  filtro_persistencia #(.DEB(DEB)) u_filtro_humo (.clk(clk), .rst(rst), .din(humo),    .dout(humo_f_s));

  // The flag that caused the active alarm, selected by the one-hot cause
  assign flag_causa_s = |(causa_r & {humo_f_s, corr_f_s, temp_f_s});

`ifdef MONITOR_ALARMAS_LATCH_EN
  logic ack_seen_r, ack_seen_next_s;

  assign salir_s = !flag_causa_s && (ack || ack_seen_r);

  // Remember an early ack for as long as the alarm state is held
  always_comb begin
    ack_seen_next_s = 1'b0;
    if (es_alarma(estado_r) && es_alarma(estado_next_s)) begin
      ack_seen_next_s = ack_seen_r | ack;
    end else begin
      ack_seen_next_s = 1'b0;
    end
  end

  // Ack memory register
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_seen_r <= 1'b0;
    end else begin
      ack_seen_r <= ack_seen_next_s;
    end
  end
`else
  logic ack_unused_s;

  assign ack_unused_s = ack;
  assign salir_s      = !flag_causa_s;
`endif

  // Next-state and cause selection; the interruptor check outranks alarm entry
  always_comb begin
    estado_next_s = estado_r;
    causa_next_s  = 3'b000;
    case (estado_r)
      INICIO: begin
        if (interruptor) estado_next_s = CHK_TEMP;
        else             estado_next_s = INICIO;
      end
      CHK_TEMP: begin
        if (!interruptor) begin
          estado_next_s = INICIO;
        end else if (temp_f_s) begin
          estado_next_s = ALERTA;
          causa_next_s  = 3'(1 << CAUSA_TEMP);
        end else begin
          estado_next_s = CHK_CORR;
        end
      end
      CHK_CORR: begin
        if (!interruptor) begin
          estado_next_s = INICIO;
        end else if (corr_f_s) begin
          estado_next_s = ALERTA;
          causa_next_s  = 3'(1 << CAUSA_CORR);
        end else begin
          estado_next_s = CHK_HUMO;
        end
      end
      CHK_HUMO: begin
        if (!interruptor) begin
          estado_next_s = INICIO;
        end else if (humo_f_s) begin
          estado_next_s = PREVEN;
          causa_next_s  = 3'(1 << CAUSA_HUMO);
        end else begin
          estado_next_s = INICIO;
        end
      end
      ALERTA, PREVEN: begin
        if (salir_s) begin
          estado_next_s = INICIO;
        end else begin
          estado_next_s = estado_r;
          causa_next_s  = causa_r;
        end
      end
      default: begin
        estado_next_s = INICIO;
      end
    endcase
  end

  // State, cause, event counter and Moore outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_r          <= INICIO;
      causa_r           <= 3'b000;
      cont_r            <= 8'd0;
      LEDalerta         <= 1'b0;
      LEDprevencion     <= 1'b0;
      LEDnormal         <= 1'b0;
      alarma_alerta     <= 1'b0;
      alarma_prevencion <= 1'b0;
    end else begin
      estado_r          <= estado_next_s;
      causa_r           <= causa_next_s;
      if (es_alarma(estado_next_s) && !es_alarma(estado_r) && (cont_r != 8'hFF)) begin
        cont_r <= cont_r + 8'd1;
      end
      LEDalerta         <= (estado_next_s == ALERTA);
      alarma_alerta     <= (estado_next_s == ALERTA);
      LEDprevencion     <= (estado_next_s == PREVEN);
      alarma_prevencion <= (estado_next_s == PREVEN);
      LEDnormal         <= (estado_next_s == CHK_TEMP) || (estado_next_s == CHK_CORR) ||
                           (estado_next_s == CHK_HUMO);
    end
  end

  assign causa        = causa_r;
  assign cont_eventos = cont_r;

endmodule

// File: tb/tb_monitor_alarmas.sv
// Directed self-checking bench for monitor_alarmas (default parameters N=5, UMBRAL=15, DEB=4).
module tb_monitor_alarmas;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst, interruptor, temp, humo, ack;
  logic [N-1:0] corriente;
  logic         LEDalerta, LEDprevencion, LEDnormal, alarma_alerta, alarma_prevencion;
  logic [2:0]   causa;
  logic [7:0]   cont_eventos;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_cnt  = 8'd0;

  monitor_alarmas dut (
    .clk(clk), .rst(rst), .interruptor(interruptor), .temp(temp), .humo(humo),
    .corriente(corriente), .ack(ack), .LEDalerta(LEDalerta), .LEDprevencion(LEDprevencion),
    .LEDnormal(LEDnormal), .alarma_alerta(alarma_alerta), .alarma_prevencion(alarma_prevencion),
    .causa(causa), .cont_eventos(cont_eventos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_alarma(input logic want, input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      step();
      if ((alarma_alerta | alarma_prevencion) == want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic contar_entrada();
    exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
  endtask

  task automatic limpiar(output logic ok);
    temp = 1'b0; humo = 1'b0; corriente = '0;
    ack = 1'b1; step(); ack = 1'b0;
    wait_alarma(1'b0, 12, ok);
  endtask

  task automatic entrar_preven();
    interruptor = 1'b0; step(); step();
    humo = 1'b1; repeat (6) step();
    interruptor = 1'b1; repeat (4) step();
  endtask

  initial begin
    logic ok;
    int   vistas, normales, perdidas;
    rst = 1'b1; interruptor = 1'b0; temp = 1'b0; humo = 1'b0; ack = 1'b0; corriente = '0;
    step(); step();
    check("reset_outs", {LEDalerta, LEDprevencion, LEDnormal, alarma_alerta, alarma_prevencion, causa}, 8'h00);
    check("reset_cont", cont_eventos, 8'd0);
    rst = 1'b0;

    // scan: T,C,H,I repeating -> 12 of 16 cycles with LEDnormal
    interruptor = 1'b1; normales = 0; vistas = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      normales += LEDnormal;
      vistas   += (alarma_alerta | alarma_prevencion);
    end
    check("scan_normal", normales, 12);
    check("scan_alarm", vistas, 0);
    check("scan_cont", cont_eventos, 8'd0);

    // threshold: 14 never alarms, 15 alarms within DEB+4
    corriente = 5'd14; vistas = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      vistas += (alarma_alerta | alarma_prevencion);
    end
    check("umbral_14", vistas, 0);
    corriente = 5'd15;
    wait_alarma(1'b1, 8, ok);
    check("umbral_15_entry", ok, 1'b1);
    check("umbral_15_alerta", alarma_alerta, 1'b1);
    check("umbral_15_causa", causa, 3'b010);
    contar_entrada();
    check("umbral_cont", cont_eventos, exp_cnt);
    limpiar(ok);
    check("umbral_exit", ok, 1'b1);
    check("umbral_causa_off", causa, 3'b000);

    // glitch: 3 cycles filtered out, 4 cycles trigger
    temp = 1'b1; repeat (3) step(); temp = 1'b0; vistas = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      vistas += (alarma_alerta | alarma_prevencion);
    end
    check("glitch_3", vistas, 0);
    temp = 1'b1; repeat (4) step(); temp = 1'b0;
    wait_alarma(1'b1, 6, ok);
    check("glitch_4_entry", ok, 1'b1);
    check("glitch_4_causa", causa, 3'b001);
    contar_entrada();
    check("glitch_cont", cont_eventos, exp_cnt);
    limpiar(ok);
    check("glitch_exit", ok, 1'b1);

    // interruptor drop in CHK_TEMP wins over alarm entry; then priority temp > humo
    interruptor = 1'b0; step(); step();
    temp = 1'b1; humo = 1'b1; repeat (6) step();
    interruptor = 1'b1; step();
    check("prio_chk_temp", LEDnormal, 1'b1);
    interruptor = 1'b0; step();
    check("prio_off_wins", {alarma_alerta, alarma_prevencion, LEDnormal}, 3'b000);
    interruptor = 1'b1; step(); step();
    check("prio_alerta", {LEDalerta, alarma_alerta, alarma_prevencion}, 3'b110);
    check("prio_causa", causa, 3'b001);
    contar_entrada();
    check("prio_cont", cont_eventos, exp_cnt);
    ack = 1'b1; step(); ack = 1'b0;
    check("prio_hold", alarma_alerta, 1'b1);
    limpiar(ok);
    check("prio_exit", ok, 1'b1);

    // latch: smoke alarm exit rule
    entrar_preven();
    check("latch_preven", {LEDprevencion, alarma_prevencion, alarma_alerta}, 3'b110);
    check("latch_causa", causa, 3'b100);
    contar_entrada();
    humo = 1'b0;
`ifdef MONITOR_ALARMAS_LATCH_EN
    repeat (8) step();
    check("latch_hold_no_ack", alarma_prevencion, 1'b1);
    ack = 1'b1; step(); ack = 1'b0;
    check("latch_ack_exit", {alarma_prevencion, LEDnormal, causa}, 5'b0);
`else
    repeat (4) step();
    check("latch_hold_deb", alarma_prevencion, 1'b1);
    step();
    check("latch_exit", {alarma_prevencion, LEDnormal, causa}, 5'b0);
`endif
    check("latch_cont", cont_eventos, exp_cnt);

    // saturation: 256 more entries
    perdidas = 0;
    for (int k = 0; k < 256; k++) begin
      temp = 1'b1;
      wait_alarma(1'b1, 10, ok);
      if (ok) contar_entrada();
      else    perdidas++;
      limpiar(ok);
      if (!ok) perdidas++;
    end
    check("sat_missed", perdidas, 0);
    check("sat_cont", cont_eventos, 8'd255);

    // reset in the middle of PREVEN
    entrar_preven();
    check("rst_pre_preven", alarma_prevencion, 1'b1);
    rst = 1'b1; step();
    check("rst_outs", {LEDalerta, LEDprevencion, LEDnormal, alarma_alerta, alarma_prevencion, causa}, 8'h00);
    check("rst_cont", cont_eventos, 8'd0);
    rst = 1'b0; humo = 1'b0; interruptor = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
